// File: rtl/tomasulo_rs_aged.sv
// tomasulo_rs_aged: N-entry reservation station that snoops the CDB, issues
// the oldest ready op through a req/gnt handshake and supports global flush.
module tomasulo_rs_aged #(
    parameter int N      = 4,
    parameter int CDB_N  = 2,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int PL_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    dis_vld,
    output logic                    dis_rdy,
    input  logic [1:0]              dis_busy,
    input  logic [2*TAG_W-1:0]      dis_tag,
    input  logic [2*DATA_W-1:0]     dis_data,
    input  logic [PL_W-1:0]         dis_payload,
    input  logic [CDB_N-1:0]        cdb_vld,
    input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
    input  logic [CDB_N*DATA_W-1:0] cdb_wdata,
    input  logic                    sch_busy,
    output logic                    iss_req,
    input  logic                    iss_gnt,
    output logic                    iss_vld_r,
    output logic [2*DATA_W-1:0]     iss_opr_r,
    output logic [PL_W-1:0]         iss_payload_r,
    output logic [$clog2(N+1)-1:0]  count_r,
    output logic                    full_r
);
    localparam int CW = $clog2(N+1);

    logic [N-1:0]        vld;
    logic [N-1:0]        rdy;
    logic [1:0]          busy    [N];
    logic [TAG_W-1:0]    tag     [N][2];
    logic [DATA_W-1:0]   data    [N][2];
    logic [PL_W-1:0]     payload [N];
    logic [N-1:0]        old     [N];

    logic [N-1:0]        elig;
    logic [N-1:0]        sel;
    logic [N-1:0]        alloc_oh;
    logic [N-1:0]        vld_nxt;
    logic [N-1:0]        rdy_nxt;
    logic [N-1:0]        any_busy;
    logic                alloc;
    logic                grant;
    logic [DATA_W:0]     lk;
    logic [1:0]          d_busy;
    logic [DATA_W-1:0]   d_data  [2];
    logic [1:0]          nb      [N];
    logic [DATA_W-1:0]   nd      [N][2];
    logic [2*DATA_W-1:0] sel_opr;
    logic [PL_W-1:0]     sel_pl;
    logic [CW-1:0]       count_nxt;

    // Returns {hit, data} of the lowest-numbered CDB port broadcasting tag t.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0] t);
        logic [DATA_W:0] r;
        r = '0;
        for (int p = CDB_N - 1; p >= 0; p--) begin
            if (cdb_vld[p] && cdb_tag[p*TAG_W +: TAG_W] == t)
                r = {1'b1, cdb_wdata[p*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    assign dis_rdy = ~full_r;

    // Oldest-ready select, handshake, dispatch bypass and entry next state.
    always_comb begin
        elig      = vld & rdy;
        sel       = '0;
        sel_opr   = '0;
        sel_pl    = '0;
        lk        = '0;
        d_busy    = '0;
        count_nxt = '0;
        for (int i = 0; i < N; i++) begin
            sel[i] = elig[i];
            for (int j = 0; j < N; j++)
                if (elig[j] && old[j][i]) sel[i] = 1'b0;
            any_busy[i] = |busy[i];
        end
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                sel_opr = sel_opr | {data[i][1], data[i][0]};
                sel_pl  = sel_pl | payload[i];
            end
        end
        iss_req  = (|elig) && !sch_busy && !flush;
        grant    = iss_req && iss_gnt;
        alloc    = dis_vld && dis_rdy && !flush;
        alloc_oh = ~vld & (vld + N'(1));
        for (int o = 0; o < 2; o++) begin
            lk        = cdb_lookup(dis_tag[o*TAG_W +: TAG_W]);
            d_busy[o] = dis_busy[o] && !lk[DATA_W];
            d_data[o] = (dis_busy[o] && lk[DATA_W]) ? lk[DATA_W-1:0]
                                                    : dis_data[o*DATA_W +: DATA_W];
        end
        for (int i = 0; i < N; i++) begin
            for (int o = 0; o < 2; o++) begin
                lk       = cdb_lookup(tag[i][o]);
                nb[i][o] = busy[i][o];
                nd[i][o] = data[i][o];
                if (alloc && alloc_oh[i]) begin
                    nb[i][o] = d_busy[o];
                    nd[i][o] = d_data[o];
                end else if (vld[i] && busy[i][o] && lk[DATA_W]) begin
                    nb[i][o] = 1'b0;
                    nd[i][o] = lk[DATA_W-1:0];
                end
            end
            vld_nxt[i] = vld[i] && !(grant && sel[i]);
            if (alloc && alloc_oh[i]) vld_nxt[i] = 1'b1;
            if (flush) vld_nxt[i] = 1'b0;
            rdy_nxt[i] = vld_nxt[i] && nb[i] == 2'b00;
            count_nxt  = count_nxt + CW'(vld_nxt[i]);
        end
    end

    // Valid, ready, age matrix, occupancy and issue-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            rdy       <= '0;
            iss_vld_r <= 1'b0;
            count_r   <= '0;
            full_r    <= 1'b0;
            for (int i = 0; i < N; i++) old[i] <= '0;
        end else begin
            vld       <= vld_nxt;
            rdy       <= rdy_nxt;
            iss_vld_r <= grant;
            count_r   <= count_nxt;
            full_r    <= count_nxt == CW'(N);
            for (int i = 0; i < N; i++) begin
                if (alloc && alloc_oh[i]) old[i] <= '0;
                for (int j = 0; j < N; j++)
                    if (alloc && alloc_oh[j]) old[i][j] <= vld[i];
            end
        end
    end

    // Operand, tag and payload storage plus issued operands; never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            busy[i]    <= nb[i];
            data[i][0] <= nd[i][0];
            data[i][1] <= nd[i][1];
            if (alloc && alloc_oh[i]) begin
                tag[i][0]  <= dis_tag[TAG_W-1:0];
                tag[i][1]  <= dis_tag[2*TAG_W-1:TAG_W];
                payload[i] <= dis_payload;
            end
        end
        if (grant) begin
            iss_opr_r     <= sel_opr;
            iss_payload_r <= sel_pl;
        end
    end

    a_one_sel: assert property (@(posedge clk) disable iff (rst)
        $onehot0(sel));
    a_count: assert property (@(posedge clk) disable iff (rst)
        count_r == CW'($countones(vld)));
    a_rdy_busy: assert property (@(posedge clk) disable iff (rst)
        (rdy & any_busy) == '0);
    a_full_drop: assert property (@(posedge clk) disable iff (rst)
        !(dis_vld && full_r))
        else $info("dispatch dropped while station full");

endmodule

// File: tb/tb_tomasulo_rs_aged.sv
// tb_tomasulo_rs_aged: directed scenarios plus randomized traffic checked
// against an age-ordered queue model of the reservation station.
module tb_tomasulo_rs_aged;
    localparam int N      = 4;
    localparam int CDB_N  = 2;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int PL_W   = 32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    flush = 1'b0;
    logic                    dis_vld = 1'b0;
    logic                    dis_rdy;
    logic [1:0]              dis_busy = '0;
    logic [2*TAG_W-1:0]      dis_tag = '0;
    logic [2*DATA_W-1:0]     dis_data = '0;
    logic [PL_W-1:0]         dis_payload = '0;
    logic [CDB_N-1:0]        cdb_vld = '0;
    logic [CDB_N*TAG_W-1:0]  cdb_tag = '0;
    logic [CDB_N*DATA_W-1:0] cdb_wdata = '0;
    logic                    sch_busy = 1'b0;
    logic                    iss_req;
    logic                    iss_gnt = 1'b0;
    logic                    iss_vld_r;
    logic [2*DATA_W-1:0]     iss_opr_r;
    logic [PL_W-1:0]         iss_payload_r;
    logic [2:0]              count_r;
    logic                    full_r;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [1:0]          b;
        logic [2*TAG_W-1:0]  t;
        logic [2*DATA_W-1:0] d;
        logic [PL_W-1:0]     pl;
    } ent_t;

    ent_t                q[$];
    logic                m_vld = 1'b0;
    logic [2*DATA_W-1:0] m_opr = '0;
    logic [PL_W-1:0]     m_pl = '0;

    always #5 clk = ~clk;

    tomasulo_rs_aged #(
        .N(N), .CDB_N(CDB_N), .TAG_W(TAG_W), .DATA_W(DATA_W), .PL_W(PL_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dis_vld(dis_vld), .dis_rdy(dis_rdy), .dis_busy(dis_busy),
        .dis_tag(dis_tag), .dis_data(dis_data), .dis_payload(dis_payload),
        .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
        .sch_busy(sch_busy), .iss_req(iss_req), .iss_gnt(iss_gnt),
        .iss_vld_r(iss_vld_r), .iss_opr_r(iss_opr_r),
        .iss_payload_r(iss_payload_r), .count_r(count_r), .full_r(full_r)
    );

    // Model: request exists when any queued op has no busy operand.
    function automatic logic m_req();
        logic r = 1'b0;
        foreach (q[k]) if (q[k].b == 2'b00) r = 1'b1;
        return r && !sch_busy && !flush;
    endfunction

    // Model: capture every busy operand from the first matching CDB port.
    function automatic ent_t resolve(input ent_t e);
        ent_t r = e;
        for (int o = 0; o < 2; o++) begin
            if (r.b[o]) begin
                for (int p = CDB_N - 1; p >= 0; p--) begin
                    if (cdb_vld[p] && cdb_tag[p*TAG_W +: TAG_W] == e.t[o*TAG_W +: TAG_W]) begin
                        r.b[o] = 1'b0;
                        r.d[o*DATA_W +: DATA_W] = cdb_wdata[p*DATA_W +: DATA_W];
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic step();
        logic req;
        logic full;
        int   k;
        ent_t e;
        req  = m_req();
        full = (q.size() == N);
        if (rst || flush) begin
            q.delete();
            m_vld = 1'b0;
        end else begin
            m_vld = iss_gnt && req;
            if (m_vld) begin
                k = 0;
                while (q[k].b != 2'b00) k++;
                m_opr = q[k].d;
                m_pl  = q[k].pl;
                q.delete(k);
            end
            foreach (q[i]) q[i] = resolve(q[i]);
            if (dis_vld && !full) begin
                e.b  = dis_busy;
                e.t  = dis_tag;
                e.d  = dis_data;
                e.pl = dis_payload;
                q.push_back(resolve(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; dis_vld = 0; dis_busy = 0; dis_tag = 0; dis_data = 0;
        dis_payload = 0; cdb_vld = 0; cdb_tag = 0; cdb_wdata = 0;
        sch_busy = 0; iss_gnt = 0;
    endtask

    task automatic dispatch(input logic [1:0] b, input logic [7:0] t,
                            input logic [63:0] d, input logic [31:0] pl);
        dis_vld = 1; dis_busy = b; dis_tag = t; dis_data = d; dis_payload = pl;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (count_r !== 3'd0) begin fails++; $display("FAIL rst_count got %0d want 0", count_r); end
        checks++; if (full_r !== 1'b0) begin fails++; $display("FAIL rst_full got %b want 0", full_r); end
        checks++; if (dis_rdy !== 1'b1) begin fails++; $display("FAIL rst_dis_rdy got %b want 1", dis_rdy); end
        checks++; if (iss_vld_r !== 1'b0) begin fails++; $display("FAIL rst_iss_vld got %b want 0", iss_vld_r); end
        checks++; if (iss_req !== 1'b0) begin fails++; $display("FAIL rst_iss_req got %b want 0", iss_req); end
    endtask

    task automatic test_simple_issue();
        dispatch(2'b00, 8'h00, {32'd7, 32'd5}, 32'h100);
        step();
        idle();
        #1;
        checks++; if (iss_req !== 1'b1) begin fails++; $display("FAIL t1_req got %b want 1", iss_req); end
        checks++; if (count_r !== 3'd1) begin fails++; $display("FAIL t1_count1 got %0d want 1", count_r); end
        iss_gnt = 1;
        step();
        iss_gnt = 0;
        #1;
        checks++; if (iss_vld_r !== 1'b1) begin fails++; $display("FAIL t1_vld got %b want 1", iss_vld_r); end
        checks++; if (iss_opr_r !== {32'd7, 32'd5}) begin fails++; $display("FAIL t1_opr got %h want %h", iss_opr_r, {32'd7, 32'd5}); end
        checks++; if (iss_payload_r !== 32'h100) begin fails++; $display("FAIL t1_pl got %h want 100", iss_payload_r); end
        checks++; if (count_r !== 3'd0) begin fails++; $display("FAIL t1_count0 got %0d want 0", count_r); end
        step();
        checks++; if (iss_vld_r !== 1'b0) begin fails++; $display("FAIL t1_vld_drop got %b want 0", iss_vld_r); end
    endtask

    task automatic test_cdb_wakeup();
        dispatch(2'b01, {4'd0, 4'd3}, {32'd1, 32'd0}, 32'hA);
        step();
        dispatch(2'b00, 8'h00, {32'd3, 32'd2}, 32'hB);
        step();
        idle();
        #1;
        checks++; if (iss_req !== 1'b1) begin fails++; $display("FAIL t2_req_b got %b want 1", iss_req); end
        iss_gnt = 1;
        step();
        iss_gnt = 0;
        checks++; if (iss_payload_r !== 32'hB || iss_vld_r !== 1'b1) begin fails++; $display("FAIL t2_first got %h/%b want b/1", iss_payload_r, iss_vld_r); end
        cdb_vld = 2'b10; cdb_tag = {4'd3, 4'd0}; cdb_wdata = {32'hAA, 32'h0};
        #1;
        checks++; if (iss_req !== 1'b0) begin fails++; $display("FAIL t2_req_wait got %b want 0", iss_req); end
        step();
        idle();
        #1;
        checks++; if (iss_req !== 1'b1) begin fails++; $display("FAIL t2_req_a got %b want 1", iss_req); end
        iss_gnt = 1;
        step();
        iss_gnt = 0;
        checks++; if (iss_payload_r !== 32'hA) begin fails++; $display("FAIL t2_pl_a got %h want a", iss_payload_r); end
        checks++; if (iss_opr_r !== {32'd1, 32'hAA}) begin fails++; $display("FAIL t2_opr_a got %h want %h", iss_opr_r, {32'd1, 32'hAA}); end
    endtask

    task automatic test_full();
        idle();
        sch_busy = 1;
        for (int k = 0; k < N; k++) begin
            dispatch(2'b00, 8'h00, {32'd0, 32'(k)}, 32'h30 + 32'(k));
            step();
        end
        dis_vld = 0;
        #1;
        checks++; if (full_r !== 1'b1) begin fails++; $display("FAIL t3_full got %b want 1", full_r); end
        checks++; if (dis_rdy !== 1'b0) begin fails++; $display("FAIL t3_dis_rdy got %b want 0", dis_rdy); end
        checks++; if (iss_req !== 1'b0) begin fails++; $display("FAIL t3_req_busy got %b want 0", iss_req); end
        dispatch(2'b00, 8'h00, 64'h0, 32'h3F);
        step();
        idle();
        checks++; if (count_r !== 3'd4) begin fails++; $display("FAIL t3_drop got %0d want 4", count_r); end
        iss_gnt = 1;
        for (int k = 0; k < N; k++) begin
            step();
            checks++; if (iss_vld_r !== 1'b1 || iss_payload_r !== 32'h30 + 32'(k)) begin fails++; $display("FAIL t3_order%0d got %h want %h", k, iss_payload_r, 32'h30 + 32'(k)); end
        end
        step();
        checks++; if (iss_vld_r !== 1'b0 || count_r !== 3'd0) begin fails++; $display("FAIL t3_empty got %b/%0d want 0/0", iss_vld_r, count_r); end
        idle();
    endtask

    task automatic test_dispatch_bypass();
        dispatch(2'b01, {4'd0, 4'd9}, {32'h22, 32'h0}, 32'h44);
        cdb_vld = 2'b01; cdb_tag = {4'd0, 4'd9}; cdb_wdata = {32'h0, 32'h11};
        step();
        idle();
        #1;
        checks++; if (iss_req !== 1'b1) begin fails++; $display("FAIL t4_req got %b want 1", iss_req); end
        iss_gnt = 1;
        step();
        iss_gnt = 0;
        checks++; if (iss_opr_r !== {32'h22, 32'h11} || iss_payload_r !== 32'h44) begin fails++; $display("FAIL t4_opr got %h want %h", iss_opr_r, {32'h22, 32'h11}); end
    endtask

    task automatic test_flush();
        dispatch(2'b00, 8'h00, 64'h1, 32'h51);
        step();
        dispatch(2'b00, 8'h00, 64'h2, 32'h52);
        step();
        dispatch(2'b00, 8'h00, 64'h3, 32'h53);
        iss_gnt = 1;
        flush = 1;
        #1;
        checks++; if (iss_req !== 1'b0) begin fails++; $display("FAIL t5_req_flush got %b want 0", iss_req); end
        step();
        idle();
        iss_gnt = 1;
        #1;
        checks++; if (count_r !== 3'd0 || full_r !== 1'b0) begin fails++; $display("FAIL t5_count got %0d/%b want 0/0", count_r, full_r); end
        checks++; if (iss_vld_r !== 1'b0) begin fails++; $display("FAIL t5_vld got %b want 0", iss_vld_r); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (iss_req !== 1'b0) begin fails++; $display("FAIL t5_no_req%0d got %b want 0", k, iss_req); end
            step();
        end
        idle();
    endtask

    task automatic test_out_of_order_free();
        logic [31:0] exp_pl [3] = '{32'h61, 32'h63, 32'h64};
        dispatch(2'b01, {4'd0, 4'd5}, {32'h1, 32'h0}, 32'h61);
        step();
        dispatch(2'b00, 8'h00, {32'h2, 32'h2}, 32'h62);
        step();
        dispatch(2'b10, {4'd6, 4'd0}, {32'h0, 32'h3}, 32'h63);
        step();
        idle();
        iss_gnt = 1;
        step();
        iss_gnt = 0;
        checks++; if (iss_payload_r !== 32'h62) begin fails++; $display("FAIL t6_first got %h want 62", iss_payload_r); end
        dispatch(2'b00, 8'h00, {32'h4, 32'h4}, 32'h64);
        step();
        idle();
        cdb_vld = 2'b11; cdb_tag = {4'd6, 4'd5}; cdb_wdata = {32'h66, 32'h55};
        step();
        idle();
        iss_gnt = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (iss_vld_r !== 1'b1 || iss_payload_r !== exp_pl[k]) begin fails++; $display("FAIL t6_order%0d got %h want %h", k, iss_payload_r, exp_pl[k]); end
        end
        checks++; if (iss_opr_r !== {32'h4, 32'h4}) begin fails++; $display("FAIL t6_opr got %h want 4_4", iss_opr_r); end
        idle();
        step();
    endtask

    task automatic test_random();
        idle();
        rst = 1;
        step();
        rst = 0;
        for (int c = 0; c < 1500; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            dis_vld     = 1'($urandom_range(0, 1));
            dis_busy    = 2'($urandom);
            dis_tag     = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            dis_data    = {$urandom, $urandom};
            dis_payload = $urandom;
            cdb_vld     = 2'($urandom);
            cdb_tag     = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            cdb_wdata   = {$urandom, $urandom};
            sch_busy    = ($urandom_range(0, 4) == 0);
            iss_gnt     = ($urandom_range(0, 9) < 7);
            #1;
            checks++; if (iss_req !== m_req()) begin fails++; $display("FAIL rnd_req c%0d got %b want %b", c, iss_req, m_req()); end
            checks++; if (dis_rdy !== (q.size() != N)) begin fails++; $display("FAIL rnd_dis_rdy c%0d got %b", c, dis_rdy); end
            step();
            checks++; if (iss_vld_r !== m_vld) begin fails++; $display("FAIL rnd_vld c%0d got %b want %b", c, iss_vld_r, m_vld); end
            if (m_vld) begin
                checks++; if (iss_opr_r !== m_opr) begin fails++; $display("FAIL rnd_opr c%0d got %h want %h", c, iss_opr_r, m_opr); end
                checks++; if (iss_payload_r !== m_pl) begin fails++; $display("FAIL rnd_pl c%0d got %h want %h", c, iss_payload_r, m_pl); end
            end
            checks++; if (count_r !== 3'(q.size())) begin fails++; $display("FAIL rnd_count c%0d got %0d want %0d", c, count_r, q.size()); end
            checks++; if (full_r !== (q.size() == N)) begin fails++; $display("FAIL rnd_full c%0d got %b", c, full_r); end
        end
        rst = 0;
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_simple_issue();
        test_cdb_wakeup();
        test_full();
        test_dispatch_bypass();
        test_flush();
        test_out_of_order_free();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
